// File: rtl/matmul_pkg.sv
// matmul_pkg: shared FSM state type and sizing/addressing helpers for the matmul engine.
package matmul_pkg;
  typedef enum logic [2:0] {IDLE, RD_A, RD_B, MAC, WR, DONE} matmul_state_t;
  function automatic int acc_w(input int data_w, input int n);
    return 2 * data_w + $clog2(n) + 1;
  endfunction
  function automatic int unsigned idx_w(input int unsigned n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  // Row-major element address: base + row*cols + col
  function automatic int unsigned elem_addr(input int unsigned base, input int unsigned row,
                                            input int unsigned cols, input int unsigned col);
    return base + row * cols + col;
  endfunction
endpackage

// File: rtl/matmul_engine_if.sv
// matmul_engine_if: start/busy handshake plus single-port memory bus of the matmul engine.
interface matmul_engine_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 16
);
  logic              i_start;
  logic              o_busy;
  logic              o_done;
  logic [ADDR_W-1:0] o_mem_addr;
  logic              o_mem_rd;
  logic [DATA_W-1:0] i_mem_data;
  logic              o_mem_wr;
  logic [DATA_W-1:0] o_mem_wdata;
  modport master (output i_start, i_mem_data,
                  input  o_busy, o_done, o_mem_addr, o_mem_rd, o_mem_wr, o_mem_wdata);
  modport slave  (input  i_start, i_mem_data,
                  output o_busy, o_done, o_mem_addr, o_mem_rd, o_mem_wr, o_mem_wdata);
endinterface

// File: rtl/matmul_mac.sv
// matmul_mac: multiply-accumulate with clear, and saturate (MATMUL_SAT_EN) or wrap result stage.
module matmul_mac import matmul_pkg::*; #(
  parameter int DATA_W = 8,
  parameter int N      = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              clr_i,
  input  logic              acc_en_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] res_o
);
  localparam int AW = acc_w(DATA_W, N);
  logic [AW-1:0] acc_q, acc_d, sum;
  // res_o reflects the sum including the current product so the last MAC can feed the write
  assign sum   = acc_q + AW'(a_i) * AW'(b_i);
  assign acc_d = clr_i ? '0 : acc_en_i ? sum : acc_q;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) acc_q <= '0;
    else acc_q <= acc_d;
`ifdef MATMUL_SAT_EN
  assign res_o = |sum[AW-1:DATA_W] ? '1 : sum[DATA_W-1:0];
`else
  assign res_o = sum[DATA_W-1:0];
`endif
endmodule

// File: rtl/matmul_engine.sv
// matmul_engine: C = A x B sequencer over one memory port; result reduction set by MATMUL_SAT_EN.
module matmul_engine import matmul_pkg::*; #(
  parameter int              M      = 2,
  parameter int              N      = 2,
  parameter int              P      = 2,
  parameter int              DATA_W = 8,
  parameter int              ADDR_W = 16,
  parameter logic [ADDR_W-1:0] A_BASE = 16'h0000,
  parameter logic [ADDR_W-1:0] B_BASE = 16'h0010,
  parameter logic [ADDR_W-1:0] C_BASE = 16'h0024
) (
  input logic            i_clk,
  input logic            i_rst_n,
  matmul_engine_if.slave bus
);
  localparam int IW = idx_w(M);
  localparam int JW = idx_w(P);
  localparam int KW = idx_w(N);
  matmul_state_t     state_q;
  logic [IW-1:0]     i_q, i_d;
  logic [JW-1:0]     j_q, j_d;
  logic [KW-1:0]     k_q;
  logic              start_q, trig, last_i, last_j, last_k;
  logic              busy_q, done_q, rd_q, wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, a_q, res;
  assign trig   = bus.i_start & ~start_q;
  assign last_i = i_q == IW'(M - 1);
  assign last_j = j_q == JW'(P - 1);
  assign last_k = k_q == KW'(N - 1);
  assign j_d    = last_j ? '0 : j_q + 1'b1;
  assign i_d    = last_j ? i_q + 1'b1 : i_q;
  matmul_mac #(.DATA_W(DATA_W), .N(N)) u_mac (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .clr_i    ((state_q == IDLE && trig) || state_q == WR),
    .acc_en_i (state_q == MAC),
    .a_i      (a_q),
    .b_i      (bus.i_mem_data),
    .res_o    (res)
  );
  // Outputs are registered from the state being entered, so they line up with that state
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      start_q <= 1'b0;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      a_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      start_q <= bus.i_start;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      done_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      case (state_q)
        IDLE: if (trig) begin
          state_q <= RD_A;
          i_q     <= '0;
          j_q     <= '0;
          k_q     <= '0;
          busy_q  <= 1'b1;
          rd_q    <= 1'b1;
          addr_q  <= A_BASE;
        end
        RD_A: begin
          state_q <= RD_B;
          rd_q    <= 1'b1;
          addr_q  <= ADDR_W'(elem_addr(32'(B_BASE), 32'(k_q), P, 32'(j_q)));
        end
        RD_B: begin
          state_q <= MAC;
          a_q     <= bus.i_mem_data;
        end
        MAC: if (!last_k) begin
          state_q <= RD_A;
          k_q     <= k_q + 1'b1;
          rd_q    <= 1'b1;
          addr_q  <= ADDR_W'(elem_addr(32'(A_BASE), 32'(i_q), N, 32'(k_q + 1'b1)));
        end else begin
          state_q <= WR;
          wr_q    <= 1'b1;
          addr_q  <= ADDR_W'(elem_addr(32'(C_BASE), 32'(i_q), P, 32'(j_q)));
          wdata_q <= res;
        end
        WR: begin
          k_q <= '0;
          j_q <= j_d;
          i_q <= i_d;
          if (last_i && last_j) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else begin
            state_q <= RD_A;
            rd_q    <= 1'b1;
            addr_q  <= ADDR_W'(elem_addr(32'(A_BASE), 32'(i_d), N, 0));
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign bus.o_busy      = busy_q;
  assign bus.o_done      = done_q;
  assign bus.o_mem_addr  = addr_q;
  assign bus.o_mem_rd    = rd_q;
  assign bus.o_mem_wr    = wr_q;
  assign bus.o_mem_wdata = wdata_q;
endmodule

// File: doc/matmul_engine.md
# matmul_engine

Parametrised matrix-multiply engine computing C = A × B for an M×N matrix A and an N×P matrix B, all stored row-major in the shared data RAM. It is the next-generation compute core under `top`, launched by the same `i_start`/`o_busy` handshake. It sequences operand reads, performs multiply-accumulate, and writes each result element back through a single memory port. Dimensions, data width, base addresses and result overflow handling are all build-time choices.

## Interface
- `M`, 2: rows of A and C (≥1)
- `N`, 2: columns of A and rows of B, i.e. the inner dimension (≥1)
- `P`, 2: columns of B and C (≥1)
- `DATA_W`, 8: element width in memory, unsigned
- `ADDR_W`, 16: memory address width
- `A_BASE`, 16'h0000: address of A[0][0]
- `B_BASE`, 16'h0010: address of B[0][0]
- `C_BASE`, 16'h0024: address of C[0][0]
- `i_clk`, input, 1: clock
- `i_rst_n`, input, 1: asynchronous active-low reset
- `i_start`, input, 1: run request; a rising edge launches one run
- `o_busy`, output, 1: high while a run is in progress
- `o_done`, output, 1: one-cycle pulse in the final cycle of a run
- `o_mem_addr`, output, ADDR_W: memory address
- `o_mem_rd`, output, 1: read strobe
- `i_mem_data`, input, DATA_W: read data, valid one cycle after `o_mem_rd`
- `o_mem_wr`, output, 1: write strobe
- `o_mem_wdata`, output, DATA_W: write data

## Operation
- Addressing is row-major:
  - A[i][k] is at `A_BASE + i*N + k`.
  - B[k][j] is at `B_BASE + k*P + j`.
  - C[i][j] is at `C_BASE + i*P + j`.
- `i_start` is registered into `start_q`. The run trigger is `i_start & ~start_q`, and it is honoured only in IDLE.
  - A level held high launches exactly one run.
  - Edges that arrive while busy are ignored and are not queued.
- FSM states: IDLE, RD_A, RD_B, MAC, WR, DONE.
  - IDLE → RD_A on trigger. This clears the accumulator and sets i, j, k to 0.
  - RD_A: drive the A[i][k] address and assert `o_mem_rd`. Go to RD_B.
  - RD_B: capture `i_mem_data` as the A operand, drive the B[k][j] address, assert `o_mem_rd`. Go to MAC.
  - MAC: add A×B (read data) to the accumulator. If k < N-1, increment k and go to RD_A; otherwise go to WR.
  - WR: drive the C[i][j] address, the result and `o_mem_wr`; clear the accumulator and set k to 0. Advance j, wrapping to 0 and incrementing i. If i = M-1 and j = P-1, go to DONE; otherwise go to RD_A.
  - DONE: assert `o_done`, then go to IDLE.
- Arithmetic:
  - All values are unsigned.
  - The accumulator is `2*DATA_W + $clog2(N)+1` bits wide and never overflows.
  - The result is reduced to DATA_W bits as described in Configuration.
- `o_mem_rd` and `o_mem_wr` are never asserted in the same cycle. There is one memory access per cycle at most.
- Reset: an asserted `i_rst_n` (low), including mid-run, forces IDLE immediately.
  - All outputs go low/zero; counters and the accumulator go to 0; `start_q` goes to 0.
  - No further memory writes occur until a new trigger.
  - If `i_start` is already high when reset is released, that counts as a rising edge and launches a run.

## Timing
- Reset values: `o_busy`=0, `o_done`=0, `o_mem_rd`=0, `o_mem_wr`=0, `o_mem_addr`=0, `o_mem_wdata`=0.
- All outputs are registered and decoded from the current state.
- The trigger is sampled at edge t. `o_busy` is high from cycle t+1 and stays high in every non-IDLE state, including DONE.
- Run length: `M*P*(3N+1) + 1` cycles. For 2×2×2 this is 29 cycles.
- `o_done` is high only in the last busy cycle. `o_busy` falls the cycle after `o_done`.
- The earliest next trigger is the cycle after `o_busy` falls.
- Read latency is fixed at 1 cycle, and the engine applies no backpressure.

## Configuration
- `MATMUL_SAT_EN` defined: a result greater than 2^DATA_W−1 is clamped to 2^DATA_W−1.
- `MATMUL_SAT_EN` undefined: the result is the low DATA_W bits of the accumulator (wrap).

## Structure
- Package `matmul_pkg` holds:
  - the state enum `matmul_state_t`;
  - the accumulator-width localparam function `acc_w(DATA_W, N)`;
  - the address-calc helper functions.
- One sub-module, `matmul_mac`: accumulator register with clear/accumulate enables, the multiplier, and the saturate-or-wrap output stage.
- The FSM, counters and memory port stay in `matmul_engine`.

## Test plan
- Basic 2×2×2: A=[1,2;3,4], B=[5,6;7,8], start edge → writes C at 0x24..0x27 = 19, 22, 43, 50. `o_busy` high for 29 cycles; `o_done` pulses once in the last of them.
- Overflow: A and B all 255, N=2, sum 130050 → with `MATMUL_SAT_EN` each C = 0xFF; without it each C = 0x02.
- Held start: `i_start` held high for 200 cycles → exactly one run (4 writes). Drop `i_start`, raise it again → a second identical run.
- Start while busy: pulse `i_start` low then high at cycle 10 of a run → ignored; total writes stay 4 and the run length stays 29.
- Reset mid-run: assert `i_rst_n` low at cycle 15 → all outputs 0 immediately. No writes after reset. A fresh start after release gives correct C.
- Non-square: M=3, N=1, P=2, A=[2;3;4], B=[5,6] → C=[10,12,15,18,20,24]. Run length 3*2*4+1 = 25 cycles.
